// File: rtl/maze_frame_reader_if.sv
// Maze read port and pixel stream bundle for maze_frame_reader.
// master = frame reader, slave = maze memory / display side.
interface maze_frame_reader_if;
    logic [10:0] maze_address;
    logic        maze_address_data;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;

    modport master (
        output maze_address,
        output pixel_data,
        output pixel_valid,
        input  maze_address_data,
        input  pixel_ready
    );

    modport slave (
        input  maze_address,
        input  pixel_data,
        input  pixel_valid,
        output maze_address_data,
        output pixel_ready
    );
endinterface

// File: rtl/maze_frame_reader.sv
// Scans the maze cell by cell and streams one RGB565 frame per frame_start,
// with the player overlaid. Define MAZE_FRAME_READER_GRID_EN to draw cell grid lines.
module maze_frame_reader #(
    parameter int          WIDTH         = 10,
    parameter int          HEIGHT        = 10,
    parameter int          CELL_PX       = 8,
    parameter int          READ_LATENCY  = 1,
    parameter logic [15:0] WALL_COLOUR   = 16'h0000,
    parameter logic [15:0] PATH_COLOUR   = 16'hFFFF,
    parameter logic [15:0] PLAYER_COLOUR = 16'hF800
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         frame_start,
    input  logic [7:0]   player_x,
    input  logic [7:0]   player_y,
    output logic         frame_busy,
    output logic         frame_done,
    output logic [2:0]   o_state_dbg,
    maze_frame_reader_if.master bus
);
    // Pixel stream: a pixel transfers at a rising edge where pixel_valid && pixel_ready;
    // while pixel_valid is high and pixel_ready low, pixel_data is held unchanged.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int          SHIFT    = $clog2(CELL_PX);
    localparam logic [15:0] LAST_ROW = 16'(HEIGHT * CELL_PX - 1);
    localparam logic [11:0] LAST_COL = 12'(WIDTH - 1);
    localparam logic [5:0]  LAST_PIC = 6'(CELL_PX - 1);
`ifdef MAZE_FRAME_READER_GRID_EN
    localparam logic [15:0] GRID_COLOUR = 16'h7BEF;
    localparam logic [15:0] ROW_MASK    = 16'(CELL_PX - 1);
`endif

    state_t      r_state;
    logic [15:0] r_px_row;
    logic [11:0] r_cell_col;
    logic [5:0]  r_px_in_cell;
    logic [1:0]  r_wait;
    logic [7:0]  r_player_x;
    logic [7:0]  r_player_y;
    logic [10:0] r_maze_address;
    logic [15:0] r_pixel_data;
    logic        r_pixel_valid;
    logic        r_frame_busy;
    logic        r_frame_done;
`ifdef MAZE_FRAME_READER_GRID_EN
    logic        r_cell_bit;
    logic        w_row_line;
`endif

    logic [15:0] w_cell_row;
    logic [10:0] w_maze_addr;
    logic        w_is_player;
    logic        w_accept;
    logic        w_last_pic;

    assign w_cell_row  = r_px_row >> SHIFT;
    assign w_maze_addr = 11'(w_cell_row * 16'(WIDTH) + {4'b0000, r_cell_col});
    // Off-maze player coordinates simply never match a scanned cell.
    assign w_is_player = ({4'b0000, r_player_x} == r_cell_col) &&
                         ({8'h00, r_player_y} == w_cell_row);
    assign w_accept    = r_pixel_valid && bus.pixel_ready;
    assign w_last_pic  = (r_px_in_cell == LAST_PIC);
`ifdef MAZE_FRAME_READER_GRID_EN
    assign w_row_line  = ((r_px_row & ROW_MASK) == 16'd0);
`endif

    function automatic logic [15:0] f_colour(input logic is_player, input logic is_wall);
        if (is_player) return PLAYER_COLOUR;
        if (is_wall)   return WALL_COLOUR;
        return PATH_COLOUR;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_px_row       <= '0;
            r_cell_col     <= '0;
            r_px_in_cell   <= '0;
            r_wait         <= '0;
            r_player_x     <= '0;
            r_player_y     <= '0;
            r_maze_address <= '0;
            r_pixel_data   <= '0;
            r_pixel_valid  <= 1'b0;
            r_frame_busy   <= 1'b0;
            r_frame_done   <= 1'b0;
`ifdef MAZE_FRAME_READER_GRID_EN
            r_cell_bit     <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_player_x   <= player_x;
                        r_player_y   <= player_y;
                        r_px_row     <= '0;
                        r_cell_col   <= '0;
                        r_px_in_cell <= '0;
                        r_frame_busy <= 1'b1;
                        r_state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_maze_address <= w_maze_addr;
                    r_wait         <= 2'(READ_LATENCY);
                    r_pixel_valid  <= 1'b0;
                    r_state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == 2'd0) begin
`ifdef MAZE_FRAME_READER_GRID_EN
                        r_cell_bit   <= bus.maze_address_data;
                        r_pixel_data <= w_is_player ? PLAYER_COLOUR : GRID_COLOUR;
`else
                        r_pixel_data <= f_colour(w_is_player, bus.maze_address_data);
`endif
                        r_pixel_valid <= 1'b1;
                        r_state       <= S_EMIT;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                S_EMIT: begin
                    if (w_accept) begin
                        if (!w_last_pic) begin
                            r_px_in_cell <= r_px_in_cell + 6'd1;
`ifdef MAZE_FRAME_READER_GRID_EN
                            // Next pixel has px_in_cell != 0; only the row line can make it grid.
                            r_pixel_data <= (w_row_line && !w_is_player) ? GRID_COLOUR
                                                                          : f_colour(w_is_player, r_cell_bit);
`endif
                        end else begin
                            r_px_in_cell  <= '0;
                            r_pixel_valid <= 1'b0;
                            if (r_cell_col == LAST_COL) begin
                                r_cell_col <= '0;
                                if (r_px_row == LAST_ROW) begin
                                    r_px_row     <= '0;
                                    r_frame_busy <= 1'b0;
                                    r_frame_done <= 1'b1;
                                    r_state      <= S_DONE;
                                end else begin
                                    r_px_row <= r_px_row + 16'd1;
                                    r_state  <= S_FETCH;
                                end
                            end else begin
                                r_cell_col <= r_cell_col + 12'd1;
                                r_state    <= S_FETCH;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.maze_address = r_maze_address;
    assign bus.pixel_data   = r_pixel_data;
    assign bus.pixel_valid  = r_pixel_valid;
    assign frame_busy       = r_frame_busy;
    assign frame_done       = r_frame_done;
    assign o_state_dbg      = r_state;
endmodule
